// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver.
// The line is synchronised through three flops, a start edge is taken from the
// two older stages, and every bit is sampled once at mid-bit on rx_s2.
// A received byte appears on po_data with a one-cycle po_flag pulse.
// A low stop bit raises a one-cycle frame_err pulse instead; the receiver then
// waits for the line to return high, so a line held low cannot retrigger it.
// busy is high whenever the receiver is outside IDLE.
module uart_rx_byte #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       busy
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int MID          = BAUD_CNT_MAX / 2;
    localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_s3;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_nxt;
    logic [7:0]       data_nxt;
    logic             flag_nxt;
    logic             err_nxt;
    logic             fall_edge;
    logic             sample;

    // The start edge uses the two oldest synchroniser stages; sampling uses rx_s2.
    assign fall_edge = ~rx_s2 & rx_s3;
    assign sample    = (baud_cnt == CNT_MID);
    assign busy      = (state != S_IDLE);

    // Three-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Bit timing: cleared on the start edge, runs in every non-idle state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= 4'd0;
        end else if (state == S_IDLE) begin
            if (fall_edge) begin
                baud_cnt <= '0;
                bit_cnt  <= 4'd0;
            end
        end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // State, shift register and registered output pulses.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            shift_reg <= 8'h00;
            po_data   <= 8'h00;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            po_data   <= data_nxt;
            po_flag   <= flag_nxt;
            frame_err <= err_nxt;
        end
    end

    // Next-state logic: start check, data shift, stop check, break wait.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        data_nxt  = po_data;
        flag_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_edge) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    state_nxt = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample) begin
                    // Right shift in from the top so the first data bit lands in bit 0.
                    shift_nxt = {rx_s2, shift_reg[7:1]};
                    if (bit_cnt == 4'd8) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (sample && (bit_cnt == 4'd9)) begin
                    if (rx_s2) begin
                        data_nxt  = shift_reg;
                        flag_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s2) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
